// File: rtl/neureka_package.sv
// Shared types and sizing constants for the input-feature buffer and its load sequencer.
package neureka_package;

  localparam int NEUREKA_INFEAT_BUFFER_SIZE_H = 8;
  localparam int NEUREKA_INFEAT_BUFFER_SIZE_W = 8;
  localparam int NEUREKA_INFEAT_SEQ_CW        = 4;

  typedef enum logic [1:0] {
    IB_IDLE    = 2'd0,
    IB_LOAD    = 2'd1,
    IB_EXTRACT = 2'd2
  } state_infeat_buffer_t;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_SCAN      = 3'd1,
    SEQ_CMD       = 3'd2,
    SEQ_WAIT_EXT  = 3'd3,
    SEQ_WAIT_CONS = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] tile_h;
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] tile_w;
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] pad_top;
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] pad_bottom;
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] pad_left;
    logic [NEUREKA_INFEAT_SEQ_CW-1:0] pad_right;
  } ctrl_infeat_seq_t;

endpackage

// File: rtl/neureka_infeat_pad_classify.sv
// Combinational per-pixel classifier: is (row, col) outside the tile (implicit)
// or inside the tile but within an explicit padding border.
module neureka_infeat_pad_classify
  import neureka_package::*;
#(
  parameter int CW = NEUREKA_INFEAT_SEQ_CW
) (
  input  logic [CW-1:0]    row,
  input  logic [CW-1:0]    col,
  input  ctrl_infeat_seq_t cfg,
  output logic             implicit_pad,
  output logic             explicit_pad
);

  localparam int SW = CW + 1;

  logic signed [SW-1:0] row_s;
  logic signed [SW-1:0] col_s;
  logic signed [SW-1:0] bot_thr;
  logic signed [SW-1:0] rgt_thr;

  assign row_s = $signed({1'b0, row});
  assign col_s = $signed({1'b0, col});

  // Thresholds go negative when padding exceeds the tile, which makes every row/col match.
  assign bot_thr = $signed({1'b0, cfg.tile_h}) - $signed({1'b0, cfg.pad_bottom});
  assign rgt_thr = $signed({1'b0, cfg.tile_w}) - $signed({1'b0, cfg.pad_right});

  assign implicit_pad = (row >= cfg.tile_h) || (col >= cfg.tile_w);

  assign explicit_pad = !implicit_pad &&
                        ((row < cfg.pad_top)  || (row_s >= bot_thr) ||
                         (col < cfg.pad_left) || (col_s >= rgt_thr));

endmodule

// File: rtl/neureka_infeat_load_sequencer.sv
// Builds per-subtile padding masks one pixel per cycle, then drives the
// input-feature buffer through load -> extract -> idle.
module neureka_infeat_load_sequencer
  import neureka_package::*;
#(
  parameter int BUF_H = NEUREKA_INFEAT_BUFFER_SIZE_H,
  parameter int BUF_W = NEUREKA_INFEAT_BUFFER_SIZE_W,
  parameter int CW    = NEUREKA_INFEAT_SEQ_CW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [CW-1:0]                tile_h_i,
  input  logic [CW-1:0]                tile_w_i,
  input  logic [CW-1:0]                pad_top_i,
  input  logic [CW-1:0]                pad_bottom_i,
  input  logic [CW-1:0]                pad_left_i,
  input  logic [CW-1:0]                pad_right_i,
  input  logic                         consumed_i,
  input  state_infeat_buffer_t         ib_state_i,
  output logic                         goto_load_o,
  output logic                         goto_idle_o,
  output logic [$clog2(BUF_H*BUF_W):0] load_len_o,
  output logic [BUF_H*BUF_W-1:0]       implicit_pad_o,
  output logic [BUF_H*BUF_W-1:0]       explicit_pad_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NPIX  = BUF_H * BUF_W;
  localparam int IDX_W = $clog2(NPIX);
  localparam int LEN_W = IDX_W + 1;

  seq_state_t       state_q, state_d;
  ctrl_infeat_seq_t cfg_q;
  logic [CW-1:0]    row_q, col_q;
  logic [NPIX-1:0]  imp_q, exp_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx;
  logic             last_col, last_pix;
  logic             pix_imp, pix_exp;

  assign last_col = (col_q == CW'(BUF_W - 1));
  assign last_pix = last_col && (row_q == CW'(BUF_H - 1));
  assign idx      = IDX_W'(row_q) * IDX_W'(BUF_W) + IDX_W'(col_q);

  neureka_infeat_pad_classify #(
    .CW (CW)
  ) i_classify (
    .row          (row_q),
    .col          (col_q),
    .cfg          (cfg_q),
    .implicit_pad (pix_imp),
    .explicit_pad (pix_exp)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pulses are gated by enable/clear so a held CMD or WAIT_CONS state cannot repeat them.
  always_comb begin
    state_d     = state_q;
    goto_load_o = 1'b0;
    goto_idle_o = 1'b0;
    done_o      = 1'b0;
    if (clear_i) begin
      state_d = SEQ_IDLE;
    end else if (enable_i) begin
      case (state_q)
        SEQ_IDLE: begin
          if (start_i) state_d = SEQ_SCAN;
        end
        SEQ_SCAN: begin
          if (last_pix) state_d = SEQ_CMD;
        end
        SEQ_CMD: begin
          goto_load_o = 1'b1;
          state_d     = SEQ_WAIT_EXT;
        end
        SEQ_WAIT_EXT: begin
          if (ib_state_i == IB_EXTRACT) state_d = SEQ_WAIT_CONS;
        end
        SEQ_WAIT_CONS: begin
          if (consumed_i) begin
            goto_idle_o = 1'b1;
            done_o      = 1'b1;
            state_d     = SEQ_IDLE;
          end
        end
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      row_q <= '0;
      col_q <= '0;
      imp_q <= '0;
      exp_q <= '0;
      len_q <= '0;
    end else if (clear_i) begin
      row_q <= '0;
      col_q <= '0;
      imp_q <= '0;
      exp_q <= '0;
      len_q <= '0;
    end else if (enable_i) begin
      if (state_q == SEQ_IDLE && start_i) begin
        cfg_q <= '{tile_h:     tile_h_i,
                   tile_w:     tile_w_i,
                   pad_top:    pad_top_i,
                   pad_bottom: pad_bottom_i,
                   pad_left:   pad_left_i,
                   pad_right:  pad_right_i};
        row_q <= '0;
        col_q <= '0;
        len_q <= '0;
      end else if (state_q == SEQ_SCAN) begin
        imp_q[idx] <= pix_imp;
        exp_q[idx] <= pix_exp;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_pix ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (last_pix) len_q <= LEN_W'(NPIX);
      end
    end
  end

  assign load_len_o     = len_q;
  assign implicit_pad_o = imp_q;
  assign explicit_pad_o = exp_q;
  assign busy_o         = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_neureka_infeat_load_sequencer.sv
// Scoreboard bench: stimulus queues expected goto_load/done events, a negedge monitor checks them.
module tb_neureka_infeat_load_sequencer;
  import neureka_package::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 enable_i = 1'b1;
  logic                 clear_i = 1'b0;
  logic                 start_i = 1'b0;
  logic [3:0]           tile_h_i = '0, tile_w_i = '0;
  logic [3:0]           pad_top_i = '0, pad_bottom_i = '0, pad_left_i = '0, pad_right_i = '0;
  logic                 consumed_i = 1'b0;
  state_infeat_buffer_t ib_state_i = IB_IDLE;
  logic                 goto_load_o, goto_idle_o, busy_o, done_o;
  logic [6:0]           load_len_o;
  logic [63:0]          implicit_pad_o, explicit_pad_o;

  neureka_infeat_load_sequencer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .tile_h_i       (tile_h_i),
    .tile_w_i       (tile_w_i),
    .pad_top_i      (pad_top_i),
    .pad_bottom_i   (pad_bottom_i),
    .pad_left_i     (pad_left_i),
    .pad_right_i    (pad_right_i),
    .consumed_i     (consumed_i),
    .ib_state_i     (ib_state_i),
    .goto_load_o    (goto_load_o),
    .goto_idle_o    (goto_idle_o),
    .load_len_o     (load_len_o),
    .implicit_pad_o (implicit_pad_o),
    .explicit_pad_o (explicit_pad_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] imp;
    logic [63:0] exp;
    int          at;
  } load_exp_t;

  typedef struct {
    logic [63:0] imp;
    logic [63:0] exp;
  } done_exp_t;

  load_exp_t load_q[$];
  done_exp_t done_q[$];
  load_exp_t le_m;
  done_exp_t de_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (goto_load_o) begin
        if (load_q.size() == 0) begin
          check("unexpected goto_load", 64'(goto_load_o), 64'd0);
        end else begin
          le_m = load_q.pop_front();
          check("load_len", 64'(load_len_o), 64'd64);
          check("goto_load cycle", 64'(cyc), 64'(le_m.at));
          check("implicit at load", implicit_pad_o, le_m.imp);
          check("explicit at load", explicit_pad_o, le_m.exp);
        end
      end
      if (done_o || goto_idle_o) begin
        if (done_q.size() == 0) begin
          check("unexpected done/goto_idle", 64'({goto_idle_o, done_o}), 64'd0);
        end else begin
          de_m = done_q.pop_front();
          check("goto_idle+done pair", 64'({goto_idle_o, done_o}), 64'd3);
          check("implicit stable at done", implicit_pad_o, de_m.imp);
          check("explicit stable at done", explicit_pad_o, de_m.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_tile(input logic [3:0] th, input logic [3:0] tw,
                          input logic [3:0] pt, input logic [3:0] pb,
                          input logic [3:0] pl, input logic [3:0] pr,
                          input logic [63:0] imp, input logic [63:0] ex,
                          input bit stall, input bit scramble);
    load_exp_t le;
    done_exp_t de;
    int n;
    tile_h_i = th; tile_w_i = tw;
    pad_top_i = pt; pad_bottom_i = pb; pad_left_i = pl; pad_right_i = pr;
    start_i = 1'b1;
    le.imp = imp;
    le.exp = ex;
    le.at  = cyc + 65 + (stall ? 10 : 0);
    load_q.push_back(le);
    tick();
    start_i = 1'b0;
    if (scramble) begin
      tile_h_i = 4'd8; tile_w_i = 4'd8;
      pad_top_i = 4'd3; pad_bottom_i = 4'd3; pad_left_i = 4'd3; pad_right_i = 4'd3;
    end
    if (stall) begin
      repeat (5) tick();
      enable_i = 1'b0;
      repeat (10) tick();
      enable_i = 1'b1;
    end
    ib_state_i = IB_LOAD;
    n = 0;
    while (!goto_load_o && n < 300) begin
      tick();
      n++;
    end
    check("goto_load within budget", 64'(goto_load_o), 64'd1);
    if (!goto_load_o) return;
    tick();
    // In WAIT_EXT: early consume and a stray start must both be ignored.
    consumed_i = 1'b1;
    start_i    = 1'b1;
    tick();
    consumed_i = 1'b0;
    start_i    = 1'b0;
    check("busy in wait_ext", 64'(busy_o), 64'd1);
    ib_state_i = IB_EXTRACT;
    tick();
    ib_state_i = IB_IDLE;
    tick();
    tick();
    de.imp = imp;
    de.exp = ex;
    done_q.push_back(de);
    consumed_i = 1'b1;
    tick();
    consumed_i = 1'b0;
    check("idle after done", 64'(busy_o), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset implicit", implicit_pad_o, 64'd0);
    check("reset explicit", explicit_pad_o, 64'd0);
    check("reset load_len", 64'(load_len_o), 64'd0);
    check("reset pulses", 64'({goto_load_o, goto_idle_o, done_o}), 64'd0);
    rst_ni = 1'b1;
    tick();

    run_tile(4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 1'b0, 1'b0);
    run_tile(4'd5, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0,
             64'hFFFF_FFC0_C0C0_C0C0, 64'h0, 1'b0, 1'b0);
    run_tile(4'd8, 4'd8, 4'd1, 4'd1, 4'd1, 4'd1,
             64'h0, 64'hFF81_8181_8181_81FF, 1'b0, 1'b0);
    run_tile(4'd6, 4'd6, 4'd1, 4'd0, 4'd0, 4'd2,
             64'hFFFF_C0C0_C0C0_C0C0, 64'h0000_3030_3030_303F, 1'b0, 1'b1);
    run_tile(4'd8, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 1'b1, 1'b0);
    run_tile(4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0);
    run_tile(4'd4, 4'd4, 4'd0, 4'd6, 4'd0, 4'd0,
             64'hFFFF_FFFF_F0F0_F0F0, 64'h0000_0000_0F0F_0F0F, 1'b0, 1'b0);

    // Clear in the 20th SCAN cycle: the previous masks are still partly set at that point.
    tile_h_i = 4'd8; tile_w_i = 4'd8;
    pad_top_i = '0; pad_bottom_i = '0; pad_left_i = '0; pad_right_i = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear busy", 64'(busy_o), 64'd0);
    check("clear implicit", implicit_pad_o, 64'd0);
    check("clear explicit", explicit_pad_o, 64'd0);
    check("clear load_len", 64'(load_len_o), 64'd0);
    repeat (80) tick();
    check("still idle after clear", 64'(busy_o), 64'd0);

    check("load queue drained", 64'(load_q.size()), 64'd0);
    check("done queue drained", 64'(done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
